// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared opcode constants and sequencer state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

   // Opcodes follow the mux bank input order i0..i7.
   localparam logic [2:0] OP_0 = 3'd0;
   localparam logic [2:0] OP_1 = 3'd1;
   localparam logic [2:0] OP_2 = 3'd2;
   localparam logic [2:0] OP_3 = 3'd3;
   localparam logic [2:0] OP_4 = 3'd4;
   localparam logic [2:0] OP_5 = 3'd5;
   localparam logic [2:0] OP_6 = 3'd6;
   localparam logic [2:0] OP_7 = 3'd7;

   typedef logic [1:0] state_t;

   localparam state_t IDLE   = 2'd0;
   localparam state_t SETTLE = 2'd1;
   localparam state_t HOLD   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module : alu_op_sequencer
// Brief  : Launches operands/select onto the ALU mux bank, waits a settle
//          time, then captures result and flags on a valid/ready output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       sel,
   input  logic [WIDTH-1:0] alu_r,
   input  logic             alu_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_carry,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

   state_t     state;
   logic [3:0] cnt;

   assign in_ready = (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         sel        <= 3'd0;
         alu_a      <= '0;
         alu_b      <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_zero   <= 1'b0;
         out_carry  <= 1'b0;
         op_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  alu_a <= in_a;
                  alu_b <= in_b;
                  sel   <= in_op;
                  cnt   <= CNT_INIT;
                  state <= SETTLE;
               end
            end
            SETTLE: begin
               // Capture on the last settle cycle; the mux bank output is
               // assumed stable only once the counter has drained.
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  out_result <= alu_r;
                  out_zero   <= (alu_r == '0);
                  out_carry  <= alu_cout;
                  out_valid  <= 1'b1;
                  state      <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  op_count  <= op_count + CNT_W'(1);
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module : tb_alu_op_sequencer
// Brief  : Two sequencer instances (settle 1 / 16-bit count, settle 3 /
//          4-bit count) driving a behavioural mux bank, checked by a model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       iv    [2];
   logic [2:0] iop   [2];
   logic [7:0] ia    [2];
   logic [7:0] ib    [2];
   logic       ordy  [2];
   logic       irdy  [2];
   logic [7:0] aa    [2];
   logic [7:0] ab    [2];
   logic [2:0] sel   [2];
   logic [7:0] r     [2];
   logic       co    [2];
   logic       ov    [2];
   logic [7:0] ores  [2];
   logic       oz    [2];
   logic       ocy   [2];
   logic [15:0] cnt  [2];
   logic [15:0] cnt0;
   logic [3:0]  cnt1;

   int checks = 0;
   int errors = 0;
   int exp_cnt [2];

   always #5 clk = ~clk;

   alu_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(1), .CNT_W(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
      .in_op(iop[0]), .in_a(ia[0]), .in_b(ib[0]), .alu_a(aa[0]), .alu_b(ab[0]),
      .sel(sel[0]), .alu_r(r[0]), .alu_cout(co[0]), .out_valid(ov[0]),
      .out_ready(ordy[0]), .out_result(ores[0]), .out_zero(oz[0]),
      .out_carry(ocy[0]), .op_count(cnt0)
   );

   alu_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(3), .CNT_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
      .in_op(iop[1]), .in_a(ia[1]), .in_b(ib[1]), .alu_a(aa[1]), .alu_b(ab[1]),
      .sel(sel[1]), .alu_r(r[1]), .alu_cout(co[1]), .out_valid(ov[1]),
      .out_ready(ordy[1]), .out_result(ores[1]), .out_zero(oz[1]),
      .out_carry(ocy[1]), .op_count(cnt1)
   );

   assign cnt[0] = cnt0;
   assign cnt[1] = {12'd0, cnt1};

   // External function units plus per-bit 8:1 mux bank
   function automatic logic [7:0] mux_bank(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
      case (s)
         OP_0:    return a & b;
         OP_1:    return a | b;
         OP_2:    return a + b;
         OP_3:    return a ^ b;
         OP_4:    return a - b;
         OP_5:    return ~a;
         OP_6:    return a;
         default: return b;
      endcase
   endfunction

   always_comb begin
      for (int d = 0; d < 2; d++) begin
         r[d]  = mux_bank(sel[d], aa[d], ab[d]);
         co[d] = ((int'(aa[d]) + int'(ab[d])) > 255);
      end
   end

   // Reference: what the operation on the accepted operands should yield
   function automatic int exp_res(input int op, input int a, input int b);
      case (op)
         0: return a & b;
         1: return a | b;
         2: return (a + b) % 256;
         3: return a ^ b;
         4: return (a - b + 256) % 256;
         5: return 255 - a;
         6: return a;
         default: return b;
      endcase
   endfunction

   function automatic int cnt_mod(input int d);
      return (d == 0) ? 65536 : 16;
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One complete operation on instance d, holding out_ready low for hold cycles
   task automatic do_op(input int d, input int op, input int a, input int b, input int hold);
      int n;
      int lat;
      int er;
      int s;
      s = (d == 0) ? 1 : 3;
      n = 0;
      while (!irdy[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_before_accept", int'(irdy[d]), 1);
      iv[d]  = 1'b1;
      iop[d] = 3'(op);
      ia[d]  = 8'(a);
      ib[d]  = 8'(b);
      @(posedge clk);
      #1;
      iv[d] = 1'b0;
      check("sel_after_accept", int'(sel[d]), op);
      check("alu_a_after_accept", int'(aa[d]), a);
      check("alu_b_after_accept", int'(ab[d]), b);
      check("in_ready_busy", int'(irdy[d]), 0);
      lat = 0;
      while (!ov[d] && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", lat, s);
      er = exp_res(op, a, b);
      check("result", int'(ores[d]), er);
      check("zero", int'(oz[d]), int'(er == 0));
      check("carry", int'(ocy[d]), int'(a + b > 255));
      repeat (hold) begin
         @(posedge clk);
         #1;
         check("hold_valid", int'(ov[d]), 1);
         check("hold_in_ready", int'(irdy[d]), 0);
         check("hold_result", int'(ores[d]), er);
      end
      @(negedge clk);
      ordy[d] = 1'b1;
      @(posedge clk);
      #1;
      ordy[d] = 1'b0;
      exp_cnt[d] = (exp_cnt[d] + 1) % cnt_mod(d);
      check("valid_after_consume", int'(ov[d]), 0);
      check("op_count", int'(cnt[d]), exp_cnt[d]);
      check("in_ready_after_consume", int'(irdy[d]), 1);
      check("result_kept", int'(ores[d]), er);
      @(negedge clk);
   endtask

   // Back-to-back opcodes 0..7 on instance 1 with out_ready tied high
   task automatic sweep();
      int issued;
      int done;
      int acc;
      int cur_op;
      int cur_a;
      int cur_b;
      issued = 0;
      done   = 0;
      acc    = 0;
      cur_op = 0;
      cur_a  = 0;
      cur_b  = 0;
      ordy[1] = 1'b1;
      for (int t = 0; t < 200 && done < 8; t++) begin
         if (ov[1]) begin
            check("sweep_result", int'(ores[1]), exp_res(cur_op, cur_a, cur_b));
            check("sweep_latency", t - acc, 3);
            check("sweep_sel", int'(sel[1]), cur_op);
            done++;
            exp_cnt[1] = (exp_cnt[1] + 1) % 16;
         end
         if (irdy[1] && issued < 8) begin
            cur_op = issued;
            cur_a  = int'($urandom_range(255));
            cur_b  = int'($urandom_range(255));
            iv[1]  = 1'b1;
            iop[1] = 3'(cur_op);
            ia[1]  = 8'(cur_a);
            ib[1]  = 8'(cur_b);
            if (issued > 0) check("sweep_spacing", t + 1 - acc, 5);
            acc = t + 1;
            issued++;
         end else begin
            iv[1] = 1'b0;
         end
         @(negedge clk);
      end
      iv[1]   = 1'b0;
      ordy[1] = 1'b0;
      check("sweep_done", done, 8);
      check("sweep_op_count", int'(cnt[1]), exp_cnt[1]);
      check("sweep_in_ready", int'(irdy[1]), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         iv[d]   = 1'b0;
         iop[d]  = 3'd0;
         ia[d]   = 8'd0;
         ib[d]   = 8'd0;
         ordy[d] = 1'b0;
         exp_cnt[d] = 0;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_in_ready", int'(irdy[0]), 1);
      check("reset_valid", int'(ov[0]), 0);
      check("reset_sel", int'(sel[1]), 0);
      rst_n = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++) begin
            check("idle_in_ready", int'(irdy[d]), 1);
            check("idle_valid", int'(ov[d]), 0);
            check("idle_sel", int'(sel[d]), 0);
            check("idle_count", int'(cnt[d]), 0);
            check("idle_result", int'(ores[d]), 0);
         end
      end
      @(negedge clk);

      do_op(0, 2, 8'hF0, 8'h20, 0);
      do_op(0, 0, 8'h0F, 8'hF0, 5);
      for (int i = 0; i < 6; i++)
         do_op(0, int'($urandom_range(7)), int'($urandom_range(255)),
               int'($urandom_range(255)), int'($urandom_range(3)));

      sweep();
      for (int i = 0; i < 9; i++)
         do_op(1, int'($urandom_range(7)), int'($urandom_range(255)),
               int'($urandom_range(255)), int'($urandom_range(2)));
      check("wrap_op_count", int'(cnt[1]), 1);

      // Abort an operation while it is settling
      iv[1]  = 1'b1;
      iop[1] = 3'd5;
      ia[1]  = 8'hAA;
      ib[1]  = 8'h55;
      @(posedge clk);
      #1;
      iv[1] = 1'b0;
      check("abort_sel_launched", int'(sel[1]), 5);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_valid", int'(ov[1]), 0);
      check("abort_sel", int'(sel[1]), 0);
      check("abort_alu_a", int'(aa[1]), 0);
      check("abort_in_ready", int'(irdy[1]), 1);
      check("abort_count0", int'(cnt[0]), 0);
      check("abort_count1", int'(cnt[1]), 0);
      exp_cnt[0] = 0;
      exp_cnt[1] = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
         check("post_abort_valid", int'(ov[1]), 0);
         check("post_abort_count", int'(cnt[1]), 0);
      end
      @(negedge clk);
      do_op(1, 4, 8'h10, 8'h20, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
